// File: rtl/rng_sched.sv
// Purpose: hands generator words to NREQ requesters, one word per grant, round-robin.
// Latency: grant issued the cycle after READY sees a request; FILL->WAIT->READY refill between grants.
// Backpressure: holds the buffered word in READY while no request is pending; reissues gen_step on timeout.
module rng_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [31:0]     rnd_out,
  output logic            gen_step,
  input  logic            gen_valid,
  input  logic [31:0]     gen_data,
  output logic            err
);

  localparam int LW = $clog2(NREQ);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     buf_q, buf_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [31:0]     rnd_q, rnd_d;
  logic            err_q, err_d;
  logic [LW-1:0]   last_q, last_d;

  logic            pick_found;
  logic [LW-1:0]   pick_idx;

  // Round-robin search: first requester at or after last_grant+1, wrapping.
  function automatic logic [LW:0] rr_pick(input logic [NREQ-1:0] r, input logic [LW-1:0] last);
    logic          found;
    logic [LW-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && r[(int'(last) + i) % NREQ]) begin
        found = 1'b1;
        win   = LW'((int'(last) + i) % NREQ);
      end
    end
    return {found, win};
  endfunction

  // Winner selection from the current request vector and fairness pointer.
  always_comb begin
    {pick_found, pick_idx} = rr_pick(req, last_q);
  end

  // Next-state and datapath: refill, wait for the generator, deliver one word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    gnt_d   = '0;
    rnd_d   = rnd_q;
    err_d   = err_q;
    last_d  = last_q;
    unique case (state_q)
      FILL: begin
        state_d = WAIT;
        cnt_d   = 8'd0;
      end
      WAIT: begin
        if (gen_valid) begin
          // A word arriving on the expiry cycle still wins: no reissue, no error.
          buf_d   = gen_data;
          state_d = READY;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = FILL;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      READY: begin
        if (pick_found) begin
          gnt_d[pick_idx] = 1'b1;
          rnd_d           = buf_q;
          last_d          = pick_idx;
          state_d         = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State registers with synchronous reset; last_grant starts at NREQ-1 so requester 0 leads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= 8'd0;
      buf_q   <= 32'd0;
      gnt_q   <= '0;
      rnd_q   <= 32'd0;
      err_q   <= 1'b0;
      last_q  <= LW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  // Outputs come straight from registers; gen_step decodes the state register only.
  always_comb begin
    gnt      = gnt_q;
    rnd_out  = rnd_q;
    err      = err_q;
    gen_step = (state_q == FILL);
  end

endmodule

// File: tb/tb_rng_sched.sv
module tb_rng_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [31:0] rnd_out;
  logic        gen_step;
  logic        gen_valid;
  logic [31:0] gen_data;
  logic        err;

  int n_checks;
  int n_fail;

  rng_sched #(.NREQ(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .rnd_out   (rnd_out),
    .gen_step  (gen_step),
    .gen_valid (gen_valid),
    .gen_data  (gen_data),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        gv;
    logic [31:0] gd;
    logic [3:0]  e_gnt;
    logic [31:0] e_rnd;
    logic        e_gs;
    logic        e_err;
  } vec_t;

  vec_t vecs[40];
  int   nvec;

  task automatic add(input logic r, input logic [3:0] rq, input logic gv, input logic [31:0] gd,
                     input logic [3:0] eg, input logic [31:0] er, input logic egs, input logic ee);
    vecs[nvec] = '{r, rq, gv, gd, eg, er, egs, ee};
    nvec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are applied just after an edge; outputs are checked 1 time unit after the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic gv, input logic [31:0] gd);
    rst = r; req = rq; gen_valid = gv; gen_data = gd;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [31:0] er,
                         input logic egs, input logic ee);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".rnd_out"}, rnd_out, er);
    chk({tag, ".gen_step"}, 32'(gen_step), 32'(egs));
    chk({tag, ".err"}, 32'(err), 32'(ee));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nvec     = 0;
    drive(1'b1, 4'b0, 1'b0, 32'd0);

    // Single requester, generator answers two cycles after gen_step.
    add(1, 4'b0001, 0, 32'h0,         4'b0000, 32'h0,         1, 0);
    add(0, 4'b0001, 0, 32'h0,         4'b0000, 32'h0,         0, 0);
    add(0, 4'b0001, 0, 32'h0,         4'b0000, 32'h0,         0, 0);
    add(0, 4'b0001, 1, 32'hDEADBEEF,  4'b0000, 32'h0,         0, 0);
    add(0, 4'b0001, 0, 32'h0,         4'b0001, 32'hDEADBEEF,  1, 0);
    add(0, 4'b0000, 0, 32'h0,         4'b0000, 32'hDEADBEEF,  0, 0);
    // All four requesting, words 1..5 must rotate 0,1,2,3,0.
    add(1, 4'b1111, 0, 32'h0,         4'b0000, 32'h0,         1, 0);
    add(0, 4'b1111, 0, 32'h0,         4'b0000, 32'h0,         0, 0);
    for (int k = 1; k <= 5; k++) begin
      add(0, 4'b1111, 0, 32'h0,     4'b0000, 32'(k - 1), 0, 0);
      add(0, 4'b1111, 1, 32'(k),    4'b0000, 32'(k - 1), 0, 0);
      add(0, 4'b1111, 0, 32'h0,     4'(1 << ((k - 1) % 4)), 32'(k), 1, 0);
      add(0, 4'b1111, 0, 32'h0,     4'b0000, 32'(k),     0, 0);
    end

    #2;
    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].gv, vecs[i].gd);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_rnd, vecs[i].e_gs, vecs[i].e_err);
    end

    // Silent generator: gen_step every 17 cycles, err from first expiry, never a grant.
    drive(1'b1, 4'b1111, 1'b0, 32'd0);
    tick();
    chk_all("to.rst", 4'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 4'b1111, 1'b0, 32'd0);
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk($sformatf("to%0d.gen_step", i), 32'(gen_step), 32'((i % 17) == 0));
      chk($sformatf("to%0d.err", i), 32'(err), 32'(i >= 17));
      chk($sformatf("to%0d.gnt", i), 32'(gnt), 32'h0);
    end

    // Word arrives exactly on the expiry cycle: accepted, no error, no reissue.
    drive(1'b1, 4'b0000, 1'b0, 32'd0);
    tick();
    drive(1'b0, 4'b0000, 1'b0, 32'd0);
    for (int i = 1; i <= 16; i++) tick();
    drive(1'b0, 4'b0000, 1'b1, 32'hA5A50034);
    tick();
    chk_all("edge.accept", 4'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("edge.hold%0d", i), 4'b0, 32'h0, 1'b0, 1'b0);
    end
    drive(1'b0, 4'b0010, 1'b0, 32'd0);
    tick();
    chk_all("edge.grant", 4'b0010, 32'hA5A50034, 1'b1, 1'b0);

    // Full buffer idles 50 cycles without refill, then goes to requester 2.
    drive(1'b0, 4'b0000, 1'b0, 32'd0);
    tick();
    drive(1'b0, 4'b0000, 1'b1, 32'hCAFE0035);
    tick();
    drive(1'b0, 4'b0000, 1'b0, 32'd0);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk($sformatf("idle%0d.gen_step", i), 32'(gen_step), 32'h0);
      chk($sformatf("idle%0d.gnt", i), 32'(gnt), 32'h0);
    end
    drive(1'b0, 4'b0100, 1'b0, 32'd0);
    tick();
    chk_all("idle.grant", 4'b0100, 32'hCAFE0035, 1'b1, 1'b0);

    // Reset while READY drops the buffered word and a late generator response.
    drive(1'b1, 4'b0000, 1'b0, 32'd0);
    tick();
    drive(1'b0, 4'b0000, 1'b0, 32'd0);
    tick();
    drive(1'b0, 4'b0000, 1'b1, 32'h12345678);
    tick();
    drive(1'b1, 4'b0001, 1'b0, 32'd0);
    tick();
    chk_all("rstr.in", 4'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 4'b0001, 1'b1, 32'h12345678);
    tick();
    chk_all("rstr.stale", 4'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 4'b0001, 1'b0, 32'd0);
    tick();
    chk_all("rstr.wait", 4'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 4'b0001, 1'b1, 32'h0BADF00D);
    tick();
    chk_all("rstr.fill", 4'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 4'b0001, 1'b0, 32'd0);
    tick();
    chk_all("rstr.grant", 4'b0001, 32'h0BADF00D, 1'b1, 1'b0);
    drive(1'b0, 4'b0000, 1'b0, 32'd0);
    tick();
    chk_all("rstr.after", 4'b0, 32'h0BADF00D, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_sched.md
RNG_SCHED -- requirements
Module: rng_sched

Interface
REQ-001 Parameter NREQ, default 4, number of random-number requesters (2..8).
REQ-002 Parameter TIMEOUT, default 16, WAIT cycles before gen_step is reissued (2..255).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 req  input  NREQ  per-requester level request, held until granted.
REQ-006 gnt  output  NREQ  registered one-hot grant, one-cycle pulse per delivered number.
REQ-007 rnd_out  output  32  registered random word, valid only in the cycle gnt is non-zero.
REQ-008 gen_step  output  1  one-cycle command to the generator to produce the next word.
REQ-009 gen_valid  input  1  generator pulse: gen_data holds a new word.
REQ-010 gen_data  input  32  generator output word.
REQ-011 err  output  1  sticky flag: at least one generator timeout since reset.

Function
REQ-012 The FSM SHALL have exactly three states: FILL, WAIT and READY.
REQ-013 gen_step SHALL be 1 exactly in cycles where state==FILL, decoded from the state register only.
REQ-014 FILL SHALL last one cycle, then go to WAIT and clear the timeout counter to 0.
REQ-015 In WAIT with gen_valid=1: latch gen_data into a 32-bit buffer and go to READY.
REQ-016 In WAIT with gen_valid=0: increment the 8-bit timeout counter.
REQ-017 When the counter equals TIMEOUT-1 with gen_valid=0: go to FILL and set err=1.
REQ-018 gen_valid in the same cycle as timeout expiry SHALL take priority: data accepted, no reissue, err unchanged.
REQ-019 gen_valid outside WAIT SHALL be ignored; the buffer and state are unchanged.
REQ-020 In READY with req==0, the FSM SHALL stay in READY holding the buffer indefinitely.
REQ-021 In READY with req!=0, select one requester round-robin, starting at index (last_grant+1) mod NREQ, searching upward with wrap.
REQ-022 The cycle after selection: gnt has one bit set at the winner, rnd_out=buffer, last_grant=winner, state=FILL.
REQ-023 gnt SHALL be 0 in every cycle other than the cycle after a READY selection.
REQ-024 rnd_out SHALL hold its last value when gnt==0.
REQ-025 Each buffered word SHALL be delivered to exactly one requester, never duplicated or dropped.
REQ-026 A req bit deasserted before selection SHALL receive no grant and SHALL NOT lose its fairness position.
REQ-027 Minimum service interval: one grant per 3 cycles plus generator latency (FILL, WAIT ≥1, READY).

Reset
REQ-028 On rst=1: state=FILL, gnt=0, rnd_out=0, err=0, buffer=0, timeout counter=0, last_grant=NREQ-1 (requester 0 has first priority).
REQ-029 rst asserted mid-operation SHALL discard any buffered word and any pending generator response.
REQ-030 gen_step SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-031 Reset, gen model answers 2 cycles after gen_step with 0xDEADBEEF, req=0001 -> gnt=0001, rnd_out=0xDEADBEEF, one pulse, then gen_step reissued.
REQ-032 req=1111 held, model returns 1,2,3,4,5 -> gnt sequence 0001,0010,0100,1000,0001 with rnd_out 1,2,3,4,5.
REQ-033 Model never answers, TIMEOUT=16 -> gen_step pulses every 17 cycles, err=1 after the first expiry, gnt stays 0.
REQ-034 gen_valid coincident with the counter reaching 15 -> word buffered, err stays 0, no extra gen_step.
REQ-035 Buffer full, req=0 for 50 cycles, then req=0100 -> no gen_step during idle; gnt=0100 with the buffered word.
REQ-036 rst pulsed while in READY with a buffered 0x12345678 -> no grant of 0x12345678; gnt=0, gen_step=1 after release.
